icode_issue_unit: RTL

ICODE_ISSUE_UNIT -- requirements
Module: icode_issue_unit

---
 rtl/lu_pkg.sv | 20 ++
 rtl/icode_prog_mem.sv | 23 ++
 rtl/icode_issue_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lu_pkg.sv
// Shared constants and state encoding for the instruction-code issue unit.
package lu_pkg;

    localparam int unsigned ICODE_W    = 8;
    localparam int unsigned PROG_DEPTH = 16;
    localparam int unsigned PC_W       = $clog2(PROG_DEPTH);
    localparam int unsigned CNT_W      = 5;

    localparam logic [ICODE_W-1:0] ICODE_NOP  = 8'h00;
    localparam logic [ICODE_W-1:0] ICODE_HALT = 8'hFF;
    localparam logic [CNT_W-1:0]   CNT_MAX    = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/icode_prog_mem.sv
// 16x8 program store: synchronous write, asynchronous read, contents never reset.
module icode_prog_mem
    import lu_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [ICODE_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [ICODE_W-1:0] rdata_c
);

    logic [ICODE_W-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/icode_issue_unit.sv
// Sequences instruction codes from a loadable program store to the processor.
// Build option ICODE_LOOP_EN: pc wraps 15->0 and issue continues until HALT.
module icode_issue_unit
    import lu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_en,
    input  logic [PC_W-1:0]    ld_addr,
    input  logic [ICODE_W-1:0] ld_data,
    input  logic               start,
    input  logic               stall,
    output logic [ICODE_W-1:0] ICODE,
    output logic               icode_vld,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   issue_cnt
);

    state_t             state_q, state_d;
    logic [ICODE_W-1:0] icode_q, icode_d;
    logic               vld_q, vld_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mem_we_c;
    logic [ICODE_W-1:0] fetch_c;
    logic               end_of_prog_c;

    icode_prog_mem u_mem (
        .clk     (clk),
        .we      (mem_we_c),
        .waddr   (ld_addr),
        .wdata   (ld_data),
        .raddr   (pc_q),
        .rdata_c (fetch_c)
    );

    // The fetched entry is the final one of the program (HALT, or top of store when not looping).
`ifdef ICODE_LOOP_EN
    assign end_of_prog_c = (fetch_c == ICODE_HALT);
`else
    assign end_of_prog_c = (fetch_c == ICODE_HALT) || (pc_q == PC_W'(PROG_DEPTH - 1));
`endif

    always_comb begin
        state_d  = state_q;
        icode_d  = icode_q;
        vld_d    = vld_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        mem_we_c = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                mem_we_c = ld_en;
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (stall) begin
                    state_d = ST_HOLD;
                end else if (last_q) begin
                    state_d = ST_DONE;
                    icode_d = ICODE_NOP;
                    vld_d   = 1'b0;
                end else begin
                    state_d = ST_RUN;
                    icode_d = fetch_c;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                    cnt_d   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
                    last_d  = end_of_prog_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
                icode_d = ICODE_NOP;
                vld_d   = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            icode_q <= ICODE_NOP;
            vld_q   <= 1'b0;
            pc_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            icode_q <= icode_d;
            vld_q   <= vld_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ICODE     = icode_q;
    assign icode_vld = vld_q;
    assign pc        = pc_q;
    assign issue_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
